march_ctrl: RTL and testbench

MARCH_CTRL -- requirements
Module: march_ctrl

---
 rtl/march_pkg.sv | 39 +++
 rtl/march_ctrl_if.sv | 14 +
 rtl/counter.sv | 22 ++
 rtl/march_ctrl.sv | 144 ++++++++++++++
 tb/tb_march_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/march_pkg.sv
// rtl/march_pkg.sv - shared types and March C- element table for march_ctrl
package march_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        OP0   = 3'd2,
        OP1   = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef logic [2:0] elem_t;

    localparam elem_t LAST_ELEM = 3'd5;

    // val is the written background for a write, the expected background for a read
    typedef struct packed {
        logic up;
        logic two_ops;
        logic op0_rd;
        logic op0_val;
        logic op1_rd;
        logic op1_val;
    } elem_cfg_t;

    function automatic elem_cfg_t elem_cfg(input elem_t e);
        case (e)
            3'd0:    elem_cfg = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            3'd1:    elem_cfg = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
            3'd2:    elem_cfg = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            3'd3:    elem_cfg = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
            3'd4:    elem_cfg = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            3'd5:    elem_cfg = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            default: elem_cfg = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/march_ctrl_if.sv
// rtl/march_ctrl_if.sv - memory-side bus between march_ctrl and the memory under test
interface march_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, output mem_we, output mem_re, output mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, input mem_we, input mem_re, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/counter.sv
// rtl/counter.sv - loadable up/down counter with terminal-count output, no reset
module counter #(
    parameter int LENGTH = 10
) (
    input  logic              clk,
    input  logic [LENGTH-1:0] d_in,
    input  logic              ld,
    input  logic              u_d,
    input  logic              cen,
    output logic [LENGTH-1:0] q,
    output logic              cout
);
    always_ff @(posedge clk) begin
        if (ld) begin
            q <= d_in;
        end else if (cen) begin
            q <= u_d ? q + LENGTH'(1) : q - LENGTH'(1);
        end
    end

    assign cout = u_d ? (&q) : ~(|q);
endmodule

// File: rtl/march_ctrl.sv
// rtl/march_ctrl.sv - March C- BIST controller; MARCH_DIAG_EN enables fail_addr/fail_elem capture
module march_ctrl
    import march_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    march_ctrl_if.master      mem
);
    state_t            state, state_nxt;
    elem_t             elem;
    elem_cfg_t         cfg;
    logic              ld, cen, u_d;
    logic [ADDR_W-1:0] d_in, q;
    logic              we, re, wbit, term, elem_end, accept, miscmp;
    logic              chk_vld;
    logic [DATA_W-1:0] chk_exp;

    counter #(.LENGTH(ADDR_W)) u_addr_cnt (
        .clk  (clk),
        .d_in (d_in),
        .ld   (ld),
        .u_d  (u_d),
        .cen  (cen),
        .q    (q),
        .cout ()
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        cfg       = elem_cfg(elem);
        state_nxt = state;
        ld        = 1'b0;
        d_in      = '0;
        cen       = 1'b0;
        u_d       = 1'b0;
        we        = 1'b0;
        re        = 1'b0;
        wbit      = 1'b0;
        elem_end  = 1'b0;
        term      = cfg.up ? (&q) : ~(|q);
        case (state)
            IDLE, DONE: if (start) state_nxt = LOAD;
            LOAD: begin
                ld        = 1'b1;
                d_in      = cfg.up ? '0 : '1;
                state_nxt = OP0;
            end
            OP0: begin
                re   = cfg.op0_rd;
                we   = ~cfg.op0_rd;
                wbit = cfg.op0_val;
                if (cfg.two_ops) begin
                    state_nxt = OP1;
                end else begin
                    cen      = 1'b1;
                    u_d      = cfg.up;
                    elem_end = term;
                end
            end
            OP1: begin
                re        = cfg.op1_rd;
                we        = ~cfg.op1_rd;
                wbit      = cfg.op1_val;
                cen       = 1'b1;
                u_d       = cfg.up;
                elem_end  = term;
                state_nxt = OP0;
            end
            DRAIN:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        // counter wrap is deliberately unused; the terminal address alone ends an element
        if (elem_end) state_nxt = (elem == LAST_ELEM) ? DRAIN : LOAD;
    end

    assign accept        = ((state == IDLE) || (state == DONE)) && start;
    assign miscmp        = chk_vld && (mem.mem_rdata != chk_exp);
    assign busy          = (state == LOAD) || (state == OP0) || (state == OP1) || (state == DRAIN);
    assign done          = (state == DONE);
    assign mem.mem_addr  = q;
    assign mem.mem_we    = we;
    assign mem.mem_re    = re;
    assign mem.mem_wdata = {DATA_W{wbit}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem    <= '0;
            chk_vld <= 1'b0;
            chk_exp <= '0;
            fail    <= 1'b0;
        end else begin
            chk_vld <= re;
            chk_exp <= {DATA_W{wbit}};
            if (accept) begin
                elem <= '0;
                fail <= 1'b0;
            end else begin
                if (elem_end && (elem != LAST_ELEM)) elem <= elem + elem_t'(1);
                if (miscmp) fail <= 1'b1;
            end
        end
    end

`ifdef MARCH_DIAG_EN
    logic [ADDR_W-1:0] chk_addr;
    elem_t             chk_elem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_addr  <= '0;
            chk_elem  <= '0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else begin
            chk_addr <= q;
            chk_elem <= elem;
            if (accept) begin
                fail_addr <= '0;
                fail_elem <= '0;
            end else if (miscmp && !fail) begin
                fail_addr <= chk_addr;
                fail_elem <= chk_elem;
            end
        end
    end
`else
    assign fail_addr = '0;
    assign fail_elem = '0;
`endif

endmodule

// File: tb/tb_march_ctrl.sv
// tb/tb_march_ctrl.sv - self-checking bench for march_ctrl against a March C- reference model
module tb_march_ctrl;
    localparam int AW = 2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;

    int n_checks = 0;
    int n_fails  = 0;

    march_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    march_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .mem       (bus)
    );

    always #5 clk = ~clk;

    // fault: bit f_bit of address f_addr reads as f_val once f_arm writes of the run have happened
    bit       f_en   = 1'b0;
    int       f_addr = 0;
    int       f_bit  = 0;
    bit       f_val  = 1'b0;
    int       f_arm  = 0;
    int       w_base = 0;

    logic [DW-1:0] mem_arr [4];
    logic [DW-1:0] rdata_r = '0;
    int            wr_cnt  = 0;
    int            rd_cnt  = 0;

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a, input int writes);
        logic [DW-1:0] r;
        r = v;
        if (f_en && (writes >= f_arm) && (a == f_addr)) r[f_bit] = f_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem_arr[bus.mem_addr] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.mem_re) begin
            rdata_r <= faulty(mem_arr[bus.mem_addr], int'(bus.mem_addr), wr_cnt - w_base);
            rd_cnt  <= rd_cnt + 1;
        end
    end
    assign bus.mem_rdata = rdata_r;

    // March C- as an algorithm: direction, ops, read/write and background per element
    bit t_up [6]     = '{1, 1, 1, 0, 0, 1};
    int t_n  [6]     = '{1, 2, 2, 2, 2, 1};
    bit t_rd [6][2]  = '{'{0, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}};
    bit t_val[6][2]  = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

    function automatic void ref_march(output bit ef, output int ea, output int ee,
                                      output int nw, output int nr);
        logic [DW-1:0] m [4];
        logic [DW-1:0] v, ex;
        int a, writes;
        ef = 0; ea = 0; ee = 0; nw = 0; nr = 0; writes = 0;
        for (int i = 0; i < 4; i++) m[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < 4; k++) begin
                a = t_up[e] ? k : 3 - k;
                for (int o = 0; o < t_n[e]; o++) begin
                    ex = t_val[e][o] ? 8'hFF : 8'h00;
                    if (t_rd[e][o]) begin
                        v = faulty(m[a], a, writes);
                        nr++;
                        if ((v != ex) && !ef) begin
                            ef = 1; ea = a; ee = e;
                        end
                    end else begin
                        m[a] = ex;
                        writes++;
                        nw++;
                    end
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_fault(input bit en, input int a, input int b, input bit v, input int arm);
        f_en = en; f_addr = a; f_bit = b; f_val = v; f_arm = arm;
    endtask

    task automatic run_check(input string tag, input int mid);
        bit ef;
        int ea, ee, nw, nr, w0, r0;
        logic [31:0] exp_fa, exp_fe;
        ref_march(ef, ea, ee, nw, nr);
`ifdef MARCH_DIAG_EN
        exp_fa = ea; exp_fe = ee;
`else
        exp_fa = 0;  exp_fe = 0;
`endif
        repeat ($urandom_range(0, 3)) @(negedge clk);
        w0 = wr_cnt; r0 = rd_cnt; w_base = wr_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // the edge just passed sampled start; count it as edge 1
        for (int e = 2; e <= 48; e++) begin
            @(negedge clk);
            start = (e == mid);
            if (e == 47) begin
                check({tag, " drain_busy"}, busy, 1);
                check({tag, " drain_done"}, done, 0);
                check({tag, " drain_fail"}, fail, ef && !(ee == 5 && ea == 3));
            end
        end
        start = 1'b0;
        check({tag, " done"}, done, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " fail"}, fail, ef);
        check({tag, " fail_addr"}, fail_addr, exp_fa);
        check({tag, " fail_elem"}, fail_elem, exp_fe);
        check({tag, " writes"}, wr_cnt - w0, nw);
        check({tag, " reads"}, rd_cnt - r0, nr);
        repeat (3) @(negedge clk);
        check({tag, " done_held"}, done, 1);
        check({tag, " fail_held"}, fail, ef);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst fail", fail, 0);
        check("rst we", bus.mem_we, 0);
        check("rst re", bus.mem_re, 0);
        check("rst wdata", bus.mem_wdata, 0);
        check("rst fail_addr", fail_addr, 0);
        check("rst fail_elem", fail_elem, 0);
        rst = 1'b0;
        @(negedge clk);

        set_fault(0, 0, 0, 0, 0);
        run_check("clean", 0);
        set_fault(1, 2, 0, 1, 0);
        run_check("sa1_a2b0", 0);
        set_fault(0, 0, 0, 0, 0);
        run_check("busy_start", 20);
        set_fault(1, 3, 7, 1, 16);
        run_check("e5_last_read", 0);

        // reset in the middle of E3 (its first OP1 write)
        set_fault(0, 0, 0, 0, 0);
        w_base = wr_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        check("e3_op1 we", bus.mem_we, 1);
        check("e3_op1 busy", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst fail", fail, 0);
        check("midrst we", bus.mem_we, 0);
        check("midrst re", bus.mem_re, 0);
        check("midrst wdata", bus.mem_wdata, 0);
        check("midrst fail_addr", fail_addr, 0);
        check("midrst fail_elem", fail_elem, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_check("after_rst", 0);

        for (int i = 0; i < 6; i++) begin
            set_fault($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7),
                      $urandom_range(0, 1), 4 * $urandom_range(0, 4));
            run_check($sformatf("rand%0d", i), ($urandom_range(0, 1) != 0) ? $urandom_range(3, 45) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
